// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: FSM state encoding, requester IDs and the 2-way winner rule
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;
  localparam logic REQ_C = 1'b0;
  localparam logic REQ_D = 1'b1;
  // A tie goes to C in fixed mode, otherwise to whoever did not win last time
  function automatic logic rr_pick(input logic c_req, input logic d_req,
                                   input logic fixed_prio, input logic last);
    return (c_req && d_req) ? (fixed_prio ? REQ_C : ~last) : (d_req ? REQ_D : REQ_C);
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way winner select with a registered last-winner pointer
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic fixed_prio,
  input  logic c_req,
  input  logic d_req,
  input  logic update,
  output logic winner
);
  logic last;
  assign winner = rr_pick(c_req, d_req, fixed_prio, last);
  // Pointer starts at D so the first tie after reset favours C
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last <= REQ_D;
    else if (update) last <= winner;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (C) and debug (D)
// ports, one transaction at a time, with registered grant and response pulses
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int CORE_PRIO = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rsp_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          win;
  logic          accept;
  assign accept = (state == ST_IDLE) && (c_req || d_req);
  rr_arb2 u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .fixed_prio(CORE_PRIO != 0),
    .c_req     (c_req),
    .d_req     (d_req),
    .update    (accept),
    .winner    (win)
  );
  // The mem_* registers double as the latched command for the whole transaction
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      c_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      c_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      rsp_rdata   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      owner       <= REQ_C;
    end else begin
      c_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      c_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      mem_en      <= 1'b0;
      case (state)
        ST_IDLE:
          if (accept) begin
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            owner     <= win;
            mem_en    <= 1'b1;
            mem_we    <= win ? d_we : c_we;
            mem_addr  <= win ? d_addr : c_addr;
            mem_wdata <= win ? d_wdata : c_wdata;
            c_gnt     <= win == REQ_C;
            d_gnt     <= win == REQ_D;
          end
        ST_ISSUE: begin
          state <= ST_WAIT;
          cnt   <= CW'(MEM_LAT);
        end
        ST_WAIT:
          if (cnt == CW'(1)) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            rsp_rdata   <= mem_we ? '0 : mem_rdata;
            c_rsp_valid <= owner == REQ_C;
            d_rsp_valid <= owner == REQ_D;
          end else cnt <= cnt - CW'(1);
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiter configurations driven by directed and random requesters,
// each checked every cycle against a transaction-level schedule model
`timescale 1ns/1ps
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bit done [3];

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, g, $time, act, exp);
    end
  endtask

  task automatic chkb(input string name, input int g, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %b expected %b", name, g, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [5:0] i);
    return i == 6'd4 ? 32'hDEADBEEF : 32'h5A00_0000 | (32'(i) * 32'h0001_0203);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int LAT  = g == 0 ? 1 : g == 1 ? 3 : 4;
    localparam int PRIO = g == 1 ? 1 : 0;
    logic        rstn, c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rsp_valid, d_gnt, d_rsp_valid, mem_en, mem_we, busy, owner;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .CORE_PRIO(PRIO)) dut (
      .clk(clk), .rstn(rstn),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rsp_valid(c_rsp_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid),
      .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Memory stand-in: read data is valid only in cycle A+LAT, garbage otherwise
    logic [31:0] mem [64];
    logic [63:0] wr_mask = '0;
    int          ecyc = 0;
    int          rd_at = -1;
    logic [5:0]  rd_idx = '0;
    function automatic logic [31:0] rd_val(input logic [5:0] i);
      return wr_mask[i] ? mem[i] : init_val(i);
    endfunction
    always @(posedge clk) begin
      ecyc <= ecyc + 1;
      if (mem_en && mem_we) begin
        mem[mem_addr[7:2]]     <= mem_wdata;
        wr_mask[mem_addr[7:2]] <= 1'b1;
      end
      if (mem_en && !mem_we) begin
        rd_at  <= ecyc + LAT;
        rd_idx <= mem_addr[7:2];
      end
      mem_rdata <= (mem_en && !mem_we && LAT == 1) ? rd_val(mem_addr[7:2]) :
                   (ecyc + 1 == rd_at) ? rd_val(rd_idx) : $urandom;
    end

    // Transaction schedule model: what each cycle must show, from the arbitration rules
    logic [31:0] ref_mem [64];
    int          ecnt = 0;
    int          free_at, rsp_at, busy_end;
    logic        rsp_d, last_d, dw, we;
    logic [31:0] rsp_data, addr, wdata;
    logic        e_cg, e_dg, e_cr, e_dr, e_en, e_we, e_busy, e_own;
    logic [31:0] e_addr, e_wdata, e_rdata;
    initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(6'(i));
      forever begin
        @(posedge clk);
        ecnt++;
        if (!rstn) begin
          {e_cg, e_dg, e_cr, e_dr, e_en, e_we, e_busy, e_own} = '0;
          e_addr = '0; e_wdata = '0; e_rdata = '0;
          free_at = 0; rsp_at = -1; busy_end = 0; last_d = 1'b1;
        end else begin
          e_cg = 1'b0; e_dg = 1'b0; e_en = 1'b0;
          e_cr = ecnt == rsp_at && !rsp_d;
          e_dr = ecnt == rsp_at && rsp_d;
          if (ecnt == rsp_at) e_rdata = rsp_data;
          e_busy = ecnt < busy_end;
          if (ecnt >= free_at && (c_req || d_req)) begin
            dw = (c_req && d_req) ? (PRIO != 0 ? 1'b0 : !last_d) : d_req;
            last_d = dw;
            we = dw ? d_we : c_we;
            addr = dw ? d_addr : c_addr;
            wdata = dw ? d_wdata : c_wdata;
            e_cg = !dw; e_dg = dw; e_en = 1'b1; e_busy = 1'b1; e_own = dw;
            e_we = we; e_addr = addr; e_wdata = wdata;
            rsp_d = dw;
            rsp_data = we ? 32'h0 : ref_mem[addr[7:2]];
            if (we) ref_mem[addr[7:2]] = wdata;
            rsp_at = ecnt + LAT + 1;
            busy_end = ecnt + LAT + 1;
            free_at = ecnt + LAT + 2;
          end
        end
      end
    end

    initial forever begin
      @(posedge clk);
      #2;
      chkb("c_gnt", g, c_gnt, e_cg);
      chkb("d_gnt", g, d_gnt, e_dg);
      chkb("c_rsp_valid", g, c_rsp_valid, e_cr);
      chkb("d_rsp_valid", g, d_rsp_valid, e_dr);
      chkb("mem_en", g, mem_en, e_en);
      chkb("busy", g, busy, e_busy);
      chkb("owner", g, owner, e_own);
      if (e_cr || e_dr || !rstn) chk("rsp_rdata", g, rsp_rdata, e_rdata);
      if (e_en || !rstn) chkb("mem_we", g, mem_we, e_we);
      if (e_busy || !rstn) begin
        chk("mem_addr", g, mem_addr, e_addr);
        chk("mem_wdata", g, mem_wdata, e_wdata);
      end
    end

    // sel: 0 c_gnt, 1 d_gnt, 2 c_rsp_valid, 3 d_rsp_valid, 4 any gnt
    task automatic wait_for(input int sel, output int t);
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if ((sel == 0 && c_gnt) || (sel == 1 && d_gnt) || (sel == 2 && c_rsp_valid) ||
            (sel == 3 && d_rsp_valid) || (sel == 4 && (c_gnt || d_gnt))) begin
          t = ecnt;
          return;
        end
      end
      checks++;
      errors++;
      $display("FAIL wait_for%0d inst%0d t=%0t: no event within 40 cycles", sel, g, $time);
      t = -1000;
    endtask

    initial begin
      int   ta, tr, tp, nrsp;
      logic [3:0] order;
      rstn = 1'b0;
      {c_req, c_we, d_req, d_we} = '0;
      {c_addr, c_wdata, d_addr, d_wdata} = '0;
      repeat (3) @(negedge clk);
      chkb("reset_owner", g, owner, 1'b0);
      chk("reset_rdata", g, rsp_rdata, 32'h0);
      rstn = 1'b1;
      // core read of the preloaded word
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      wait_for(0, ta);
      c_req = 1'b0;
      chkb("t1_mem_en", g, mem_en, 1'b1);
      chk("t1_mem_addr", g, mem_addr, 32'h10);
      wait_for(2, tr);
      chk("t1_latency", g, 32'(tr - ta), 32'(LAT + 1));
      chk("t1_rdata", g, rsp_rdata, 32'hDEADBEEF);
      // debug write, then core read back
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      wait_for(1, ta);
      d_req = 1'b0;
      wait_for(3, tr);
      chk("t2_latency", g, 32'(tr - ta), 32'(LAT + 1));
      chk("t2_wack", g, rsp_rdata, 32'h0);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
      wait_for(0, ta);
      c_req = 1'b0;
      wait_for(2, tr);
      chk("t2_readback", g, rsp_rdata, 32'h12345678);
      // debug request rising while core is being served
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h84;
      wait_for(0, ta);
      c_req = 1'b0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
      wait_for(2, tr);
      chk("t6_c_latency", g, 32'(tr - ta), 32'(LAT + 1));
      wait_for(1, tr);
      chk("t6_d_accept", g, 32'(tr - ta), 32'(LAT + 2));
      d_req = 1'b0;
      wait_for(3, tr);
      // reset in the middle of a transaction
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
      wait_for(0, ta);
      c_req = 1'b0;
      repeat (LAT >= 2 ? 2 : 1) @(negedge clk);
      rstn = 1'b0;
      #1;
      chkb("t5_busy", g, busy, 1'b0);
      chkb("t5_c_rsp", g, c_rsp_valid, 1'b0);
      chk("t5_mem_addr", g, mem_addr, 32'h0);
      chk("t5_rdata", g, rsp_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      nrsp = 0;
      repeat (LAT + 3) begin
        @(negedge clk);
        nrsp += int'(c_rsp_valid) + int'(d_rsp_valid);
      end
      chk("t5_no_rsp", g, 32'(nrsp), 32'h0);
      // both requesters held high
      c_req = 1'b1; c_we = 1'b0; c_addr = $urandom;
      d_req = 1'b1; d_we = 1'b0; d_addr = $urandom;
      tp = 0;
      for (int k = 0; k < 4; k++) begin
        wait_for(4, tr);
        order[k] = d_gnt;
        if (k > 0) chk("t3_spacing", g, 32'(tr - tp), 32'(LAT + 2));
        tp = tr;
        if (k == 3) c_req = 1'b0;
      end
      chk("t3_order", g, 32'(order), PRIO != 0 ? 32'h0 : 32'hA);
      wait_for(1, tr);
      chk("t4_d_after_c_drop", g, 32'(tr - tp), 32'(LAT + 2));
      d_req = 1'b0;
      // random traffic
      repeat (500) begin
        @(negedge clk);
        if (c_gnt || !c_req) begin
          c_req = c_gnt ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
          c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
        end else if ($urandom_range(0, 15) == 0) c_req = 1'b0;
        if (d_gnt || !d_req) begin
          d_req = d_gnt ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
          d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
      end
      c_req = 1'b0;
      d_req = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int n = 0; n < 5000 && !(done[0] && done[1] && done[2]); n++) @(negedge clk);
    if (!(done[0] && done[1] && done[2])) begin
      errors++;
      $display("FAIL run_timeout: directed/random sequences did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between two requesters: the core load/store port (requester C) and the debug/loader port (requester D).
- Runs an IDLE -> ISSUE -> WAIT sequence per transaction, with one transaction outstanding at a time.
- Arbitrates simultaneous requests by fixed priority or round-robin.
- Returns a registered response pulse (read data or write ack) to the winner.
- Sits between the core's dmem interface, the debug port and the dmem instance in the top level.

Parameters:
AW, 32, address width (byte address, passed through unchanged, including [1:0]).
DW, 32, data width.
MEM_LAT, 1, memory read latency in cycles, from the mem_en cycle to the cycle mem_rdata is valid. Legal range 1..15.
CORE_PRIO, 0, 1 = fixed priority (C always wins ties), 0 = round-robin.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
c_req  in  1  core request; command must be held stable until c_gnt
c_we  in  1  core write enable (1 = write, 0 = read)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_gnt  out  1  one-cycle grant pulse to core
c_rsp_valid  out  1  one-cycle response pulse to core
d_req  in  1  debug request
d_we  in  1  debug write enable
d_addr  in  AW  debug address
d_wdata  in  DW  debug write data
d_gnt  out  1  one-cycle grant pulse to debug
d_rsp_valid  out  1  one-cycle response pulse to debug
rsp_rdata  out  DW  response data, shared by both requesters, valid only with a rsp_valid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high in ISSUE and WAIT
owner  out  1  current or last winner (0 = C, 1 = D)

Behaviour:
- Reset: the already-decided interface is reset rstn, asynchronous, active-low, clock clk.
  - State IDLE.
  - All outputs 0, including rsp_rdata, mem_* and owner.
  - Round-robin pointer set to favour C.
  - Reset asserted mid-transaction abandons it: no rsp_valid and no further mem_en.
- All outputs are registered.
- Cycle n means the cycle after clock edge n.
- IDLE:
  - Samples c_req and d_req.
  - Any request present at edge A: latch the winner's we/addr/wdata, go to ISSUE, set owner.
  - No request: remain in IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both with CORE_PRIO=1: C wins.
  - Both with CORE_PRIO=0: the requester that did not win the previous arbitration wins. The first tie after reset goes to C.
- ISSUE (cycle A, exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata carry the latched command.
  - Winner's gnt=1.
  - Next state WAIT; load a latency counter of width clog2(MEM_LAT+1).
- WAIT (cycles A+1 .. A+MEM_LAT):
  - mem_en=0; mem_addr/mem_wdata hold their values.
  - The counter decrements each cycle; all requests are ignored.
  - On the last WAIT cycle, mem_rdata is captured:
    - read: rsp_rdata <= mem_rdata
    - write: rsp_rdata <= 0
  - Next state IDLE.
- Response: the winner's rsp_valid=1 for exactly cycle A+MEM_LAT+1, which is also an IDLE cycle.
- Throughput: next acceptance is at edge A+MEM_LAT+2 at the earliest.
  - MEM_LAT=1 gives 3 cycles per transaction.
  - Latency from accept edge to rsp_valid is MEM_LAT+1 cycles.
- Requester rules:
  - A req still high in IDLE after its own gnt counts as a new request.
  - A requester with nothing further must drop req in the gnt cycle.
- Invariants:
  - c_gnt and d_gnt are never both high.
  - c_rsp_valid and d_rsp_valid are never both high.
  - gnt never occurs outside ISSUE.
- Edge cases:
  - A requester that drops req before gnt, while IDLE, is simply not arbitrated.
  - Dropping req after acceptance does not cancel the transaction.
  - Addresses are not checked; out-of-range handling belongs to dmem.

Decomposition:
- Shared package: state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2; requester IDs REQ_C=1'b0, REQ_D=1'b1.
- One natural sub-module: rr_arb2, the combinational 2-way winner select plus registered last-winner pointer, with a fixed-priority mode input.
- FSM, command latch and counter stay in dmem_arbiter.

Test Plan:
1. Core read, MEM_LAT=1: memory model holds 0xDEADBEEF at 0x10; c_req, c_addr=0x10 accepted at edge A -> c_gnt and mem_en in cycle A with mem_addr=0x10, c_rsp_valid in cycle A+2 with rsp_rdata=0xDEADBEEF, d_* outputs stay 0.
2. Debug write then core read, MEM_LAT=3: d write 0x12345678 to 0x40, then c read of 0x40 -> d_rsp_valid at A+4 with rsp_rdata=0; c read returns 0x12345678.
3. Round-robin, CORE_PRIO=0: c_req and d_req held high for 4 transactions -> grant order C, D, C, D, with acceptances spaced MEM_LAT+2 cycles apart.
4. Fixed priority, CORE_PRIO=1: both held high for 3 transactions -> C, C, C; d_gnt never asserted; dropping c_req then yields d_gnt.
5. Reset mid-WAIT, MEM_LAT=4: rstn low in cycle A+2 -> all outputs 0 immediately, no rsp_valid follows, first arbitration after release favours C.
6. Request during WAIT: d_req rises in cycle A+1 while C is being served -> no d_gnt before c_rsp_valid; d accepted at edge A+MEM_LAT+2.
